// File: rtl/time_of_day_counter_if.sv
// Bundle of the time-of-day counter's tick, control, load and display signals.
// The master side drives pulse/control/load fields; the slave side is the counter.
interface time_of_day_counter_if;
  logic       puls_1;
  logic       run;
  logic       load;
  logic [7:0] load_hour;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       load_pm;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       pm;
  logic       min_carry;
  logic       hour_carry;
  logic       day_carry;
  logic       load_err;

  modport master (
    output puls_1, run, load, load_hour, load_min, load_sec, load_pm,
    input  hour_bcd, min_bcd, sec_bcd, pm, min_carry, hour_carry, day_carry, load_err
  );

  modport slave (
    input  puls_1, run, load, load_hour, load_min, load_sec, load_pm,
    output hour_bcd, min_bcd, sec_bcd, pm, min_carry, hour_carry, day_carry, load_err
  );
endinterface

// File: rtl/time_of_day_counter.sv
// Packed-BCD hh:mm:ss counter advanced by rising edges of the one-second pulse,
// with a validated time load, run/pause control and registered rollover strobes.
module time_of_day_counter #(
  parameter int HOUR_MODE = 24
) (
  input logic                  clk,
  input logic                  rst_n,
  time_of_day_counter_if.slave bus
);

  localparam logic [7:0] HOUR_RST = (HOUR_MODE == 12) ? 8'h12 : 8'h00;

  logic       puls_q;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       pm_q, pm_d;
  logic       min_carry_q, min_carry_d;
  logic       hour_carry_q, hour_carry_d;
  logic       day_carry_q, day_carry_d;
  logic       load_err_q, load_err_d;
  logic       tick;
  logic       load_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic sexa_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
  endfunction

  // Packed BCD with units <= 9 compares correctly as a plain byte.
  function automatic logic hour_ok(input logic [7:0] v);
    if (v[3:0] > 4'd9) return 1'b0;
    if (HOUR_MODE == 12) return (v >= 8'h01) && (v <= 8'h12);
    return v <= 8'h23;
  endfunction

  assign tick    = bus.puls_1 & ~puls_q;
  assign load_ok = hour_ok(bus.load_hour) && sexa_ok(bus.load_min) && sexa_ok(bus.load_sec);

  always_comb begin
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    pm_d         = pm_q;
    min_carry_d  = 1'b0;
    hour_carry_d = 1'b0;
    day_carry_d  = 1'b0;
    load_err_d   = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        hour_d = bus.load_hour;
        min_d  = bus.load_min;
        sec_d  = bus.load_sec;
        pm_d   = (HOUR_MODE == 12) ? bus.load_pm : 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick && bus.run) begin
      if (sec_q != 8'h59) begin
        sec_d = bcd_inc(sec_q);
      end else begin
        sec_d       = 8'h00;
        min_carry_d = 1'b1;
        if (min_q != 8'h59) begin
          min_d = bcd_inc(min_q);
        end else begin
          min_d        = 8'h00;
          hour_carry_d = 1'b1;
          if (HOUR_MODE == 12) begin
            // The day ends when the 11->12 step takes PM back to AM.
            if (hour_q == 8'h12) begin
              hour_d = 8'h01;
            end else begin
              hour_d = bcd_inc(hour_q);
              if (hour_q == 8'h11) begin
                pm_d        = ~pm_q;
                day_carry_d = pm_q;
              end
            end
          end else if (hour_q == 8'h23) begin
            hour_d      = 8'h00;
            day_carry_d = 1'b1;
          end else begin
            hour_d = bcd_inc(hour_q);
          end
        end
      end
    end
  end

  // Edge detector resets high so a pulse already asserted at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      puls_q       <= 1'b1;
      hour_q       <= HOUR_RST;
      min_q        <= 8'h00;
      sec_q        <= 8'h00;
      pm_q         <= 1'b0;
      min_carry_q  <= 1'b0;
      hour_carry_q <= 1'b0;
      day_carry_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      puls_q       <= bus.puls_1;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      pm_q         <= pm_d;
      min_carry_q  <= min_carry_d;
      hour_carry_q <= hour_carry_d;
      day_carry_q  <= day_carry_d;
      load_err_q   <= load_err_d;
    end
  end

  assign bus.hour_bcd   = hour_q;
  assign bus.min_bcd    = min_q;
  assign bus.sec_bcd    = sec_q;
  assign bus.pm         = pm_q;
  assign bus.min_carry  = min_carry_q;
  assign bus.hour_carry = hour_carry_q;
  assign bus.day_carry  = day_carry_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for the time-of-day counter: one 24h and one 12h instance,
// directed vectors push expected outputs, a monitor pops and compares them.
module tb_time_of_day_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  time_of_day_counter_if a24 ();
  time_of_day_counter_if a12 ();

  time_of_day_counter #(.HOUR_MODE(24)) u24 (.clk(clk), .rst_n(rst_n), .bus(a24.slave));
  time_of_day_counter #(.HOUR_MODE(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(a12.slave));

  typedef struct {
    bit         sel;
    logic [7:0] h, m, s;
    logic       p, mc, hc, dc, le;
    string      name;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input bit sel, input logic [7:0] h, m, s,
                     input logic p, mc, hc, dc, le, input string nm);
    exp_t e;
    e.sel = sel; e.h = h; e.m = m; e.s = s;
    e.p = p; e.mc = mc; e.hc = hc; e.dc = dc; e.le = le; e.name = nm;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_puls(input bit sel, input logic v);
    if (sel) a12.puls_1 = v; else a24.puls_1 = v;
  endtask

  task automatic set_load(input bit sel, input logic ld, input logic [7:0] h, m, s, input logic p);
    if (sel) begin
      a12.load = ld; a12.load_hour = h; a12.load_min = m; a12.load_sec = s; a12.load_pm = p;
    end else begin
      a24.load = ld; a24.load_hour = h; a24.load_min = m; a24.load_sec = s; a24.load_pm = p;
    end
  endtask

  // One-cycle pulse: the advanced time and strobes, then the same time with strobes cleared.
  task automatic pulse(input bit sel, input logic [7:0] h, m, s,
                       input logic p, mc, hc, dc, input string nm);
    set_puls(sel, 1'b1);
    chk(sel, h, m, s, p, mc, hc, dc, 1'b0, nm);
    cyc();
    set_puls(sel, 1'b0);
    chk(sel, h, m, s, p, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_after"});
    cyc();
  endtask

  task automatic do_load(input bit sel, input logic [7:0] lh, lm, ls, input logic lp,
                         input logic [7:0] eh, em, es, input logic ep, le, input string nm);
    set_load(sel, 1'b1, lh, lm, ls, lp);
    chk(sel, eh, em, es, ep, 1'b0, 1'b0, 1'b0, le, nm);
    cyc();
    set_load(sel, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk(sel, eh, em, es, ep, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_after"});
    cyc();
  endtask

  initial begin : monitor
    exp_t       e;
    logic [28:0] act, req;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        e   = q.pop_front();
        req = {e.h, e.m, e.s, e.p, e.mc, e.hc, e.dc, e.le};
        if (e.sel)
          act = {a12.hour_bcd, a12.min_bcd, a12.sec_bcd, a12.pm,
                 a12.min_carry, a12.hour_carry, a12.day_carry, a12.load_err};
        else
          act = {a24.hour_bcd, a24.min_bcd, a24.sec_bcd, a24.pm,
                 a24.min_carry, a24.hour_carry, a24.day_carry, a24.load_err};
        n_checks++;
        if (act !== req) begin
          n_fail++;
          $display("FAIL %s: got hms=%h:%h:%h pm/mc/hc/dc/err=%b, required hms=%h:%h:%h pm/mc/hc/dc/err=%b",
                   e.name, act[28:21], act[20:13], act[12:5], act[4:0],
                   req[28:21], req[20:13], req[12:5], req[4:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    a24.puls_1 = 1'b1; a24.run = 1'b1;
    a12.puls_1 = 1'b0; a12.run = 1'b1;
    set_load(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    set_load(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Reset values, and a pulse held high through reset release gives no tick
    chk(1, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, 0, "reset12");
    for (int i = 0; i < 10; i++) begin
      chk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, "held_high");
      cyc();
    end
    set_puls(0, 1'b0);
    chk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, "drop");
    cyc();
    set_puls(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk(0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 0, "wide_pulse_one_tick");
      cyc();
    end
    set_puls(0, 1'b0);
    chk(0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 0, "wide_pulse_end");
    cyc();

    // Seconds rollover into minutes
    do_load(0, 8'h00, 8'h00, 8'h58, 0, 8'h00, 8'h00, 8'h58, 0, 0, "load_000058");
    pulse(0, 8'h00, 8'h00, 8'h59, 0, 0, 0, 0, "tick_59");
    pulse(0, 8'h00, 8'h01, 8'h00, 0, 1, 0, 0, "min_roll");

    // Full-day cascade in 24h mode
    do_load(0, 8'h23, 8'h59, 8'h59, 0, 8'h23, 8'h59, 8'h59, 0, 0, "load_235959");
    pulse(0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 1, "day_roll24");
    pulse(0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, "after_day24");

    // 12h mode: AM->PM, PM->AM day boundary, 12->01
    do_load(1, 8'h11, 8'h59, 8'h59, 0, 8'h11, 8'h59, 8'h59, 0, 0, "load12_am");
    pulse(1, 8'h12, 8'h00, 8'h00, 1, 1, 1, 0, "noon");
    do_load(1, 8'h11, 8'h59, 8'h59, 1, 8'h11, 8'h59, 8'h59, 1, 0, "load12_pm");
    pulse(1, 8'h12, 8'h00, 8'h00, 0, 1, 1, 1, "midnight12");
    do_load(1, 8'h12, 8'h59, 8'h59, 0, 8'h12, 8'h59, 8'h59, 0, 0, "load12_1259");
    pulse(1, 8'h01, 8'h00, 8'h00, 0, 1, 1, 0, "twelve_to_one");
    do_load(1, 8'h00, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'h00, 0, 1, "bad12_hour00");
    do_load(1, 8'h13, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 0, 1, "bad12_hour13");

    // Rejected loads in 24h mode (time is 00:00:01)
    do_load(0, 8'h24, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h01, 0, 1, "bad_hour24");
    do_load(0, 8'h00, 8'h60, 8'h00, 0, 8'h00, 8'h00, 8'h01, 0, 1, "bad_min60");
    do_load(0, 8'h00, 8'h00, 8'h0A, 0, 8'h00, 8'h00, 8'h01, 0, 1, "bad_sec0A");

    // Load wins over a coincident tick
    do_load(0, 8'h10, 8'h00, 8'h00, 0, 8'h10, 8'h00, 8'h00, 0, 0, "load_100000");
    set_load(0, 1'b1, 8'h05, 8'h06, 8'h07, 1'b0);
    set_puls(0, 1'b1);
    chk(0, 8'h05, 8'h06, 8'h07, 0, 0, 0, 0, 0, "load_vs_tick");
    cyc();
    set_load(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    set_puls(0, 1'b0);
    chk(0, 8'h05, 8'h06, 8'h07, 0, 0, 0, 0, 0, "load_vs_tick_after");
    cyc();

    // Paused ticks are discarded
    a24.run = 1'b0;
    for (int i = 0; i < 5; i++) pulse(0, 8'h05, 8'h06, 8'h07, 0, 0, 0, 0, "paused");
    a24.run = 1'b1;
    pulse(0, 8'h05, 8'h06, 8'h08, 0, 0, 0, 0, "resume");

    // Asynchronous reset mid-count, checked before any clock edge
    do_load(0, 8'h07, 8'h30, 8'h44, 0, 8'h07, 8'h30, 8'h44, 0, 0, "load_073044");
    pulse(0, 8'h07, 8'h30, 8'h45, 0, 0, 0, 0, "tick_073045");
    #1;
    rst_n = 1'b0;
    #1;
    chk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, "async_reset24");
    chk(1, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, 0, "async_reset12");
    -> chk_ev;
    cyc();
    rst_n = 1'b1;
    chk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, "post_reset24");
    cyc();
    pulse(0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, "post_reset_tick");

    cyc();
    cyc();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
